rv64_decode_stage: RTL and testbench

//  Registered RV64 decode stage; producer side of the ALU interface.

---
 rtl/rv64_pkg.sv | 67 ++++++
 rtl/rv64_imm_gen.sv | 30 +++
 rtl/rv64_decode_stage.sv | 210 +++++++++++++++++++++
 tb/tb_rv64_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// rtl/rv64_pkg.sv - shared types and encodings for the RV64 decode stage
// Contents:
//   alu_op_t        ALU operation codes driven to the ALU
//   imm_sel_t       immediate format selector for rv64_imm_gen
//   OPC_/F3_/F7_/F6_ opcode, funct3, funct7 and shift funct6 encodings
//   decode_bundle_t one decoded instruction; used for both buffer entries
package rv64_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SRA  = 4'b1110
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_SHAMT = 3'd4
  } imm_sel_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_DOUBLE  = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  // RV64 shifts-by-immediate use a 6-bit shamt, leaving only funct6 to decode
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  typedef struct packed {
    alu_op_t         alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            branch_ne;
    logic            illegal;
  } decode_bundle_t;

endpackage

// File: rtl/rv64_imm_gen.sv
// rtl/rv64_imm_gen.sv - immediate extraction and sign extension
// Ports:
//   instr  in   32  raw instruction word
//   sel    in   3   imm_sel_t format selector
//   imm    out  64  sign-extended I/S/B immediate, zero-extended shamt, else 0
module rv64_imm_gen
  import rv64_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm
);

  // funct3/rs1 and opcode never contribute to an immediate
  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};

  always_comb begin
    imm = '0;
    case (sel)
      IMM_I:     imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
      IMM_SHAMT: imm = {{(XLEN-6){1'b0}}, instr[25:20]};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/rv64_decode_stage.sv
// rtl/rv64_decode_stage.sv - registered RV64 decode stage with 2-entry skid buffer
// Ports:
//   clk, rst (async, active-high), flush (sync drop of all entries)
//   in_valid/in_ready/in_instr      instruction input handshake
//   out_valid/out_ready             decoded bundle handshake
//   out_alu_op, out_rs1/rs2/rd, out_imm, out_use_imm, out_reg_write,
//   out_mem_read, out_mem_write, out_branch, out_branch_ne, out_illegal
module rv64_decode_stage
  import rv64_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_op,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN_P-1:0] out_imm,
  output logic              out_use_imm,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_branch_ne,
  output logic              out_illegal
);

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic [5:0]     funct6;
  imm_sel_t       imm_sel;
  logic [XLEN-1:0] imm_val;
  logic           legal;
  decode_bundle_t core;
  decode_bundle_t dec;

  decode_bundle_t main_q;
  decode_bundle_t skid_q;
  logic           main_valid;
  logic           skid_valid;
  logic           accept;
  logic           drain;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign funct6 = in_instr[31:26];

  rv64_imm_gen u_imm_gen (
    .instr (in_instr),
    .sel   (imm_sel),
    .imm   (imm_val)
  );

  always_comb begin
    core      = '0;
    imm_sel   = IMM_NONE;
    legal     = 1'b0;
    core.rs1  = in_instr[19:15];
    core.rs2  = in_instr[24:20];
    core.rd   = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        core.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD_SUB: core.alu_op = ALU_ADD;
            F3_SLL:     core.alu_op = ALU_SLL;
            F3_SLTU:    core.alu_op = ALU_SLTU;
            F3_SRL_SRA: core.alu_op = ALU_SRL;
            F3_OR:      core.alu_op = ALU_OR;
            F3_AND:     core.alu_op = ALU_AND;
            default:    legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD_SUB: core.alu_op = ALU_SUB;
            F3_SRL_SRA: core.alu_op = ALU_SRA;
            default:    legal = 1'b0;
          endcase
        end
      end
      OPC_OP_IMM: begin
        core.reg_write = 1'b1;
        core.use_imm   = 1'b1;
        imm_sel        = IMM_I;
        legal          = 1'b1;
        case (funct3)
          F3_ADD_SUB: core.alu_op = ALU_ADD;
          F3_SLTU:    core.alu_op = ALU_SLTU;
          F3_OR:      core.alu_op = ALU_OR;
          F3_AND:     core.alu_op = ALU_AND;
          F3_SLL: begin
            imm_sel     = IMM_SHAMT;
            core.alu_op = ALU_SLL;
            legal       = (funct6 == F6_BASE);
          end
          F3_SRL_SRA: begin
            imm_sel = IMM_SHAMT;
            if (funct6 == F6_BASE)     core.alu_op = ALU_SRL;
            else if (funct6 == F6_ALT) core.alu_op = ALU_SRA;
            else                       legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal          = (funct3 == F3_DOUBLE);
        imm_sel        = IMM_I;
        core.alu_op    = ALU_ADD;
        core.use_imm   = 1'b1;
        core.mem_read  = 1'b1;
        core.reg_write = 1'b1;
      end
      OPC_STORE: begin
        legal          = (funct3 == F3_DOUBLE);
        imm_sel        = IMM_S;
        core.alu_op    = ALU_ADD;
        core.use_imm   = 1'b1;
        core.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        legal          = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        imm_sel        = IMM_B;
        core.alu_op    = ALU_SUB;
        core.branch    = 1'b1;
        core.branch_ne = (funct3 == F3_BNE);
      end
      default: legal = 1'b0;
    endcase
    // Illegal bundles still flow downstream but must not cause side effects
    if (!legal) begin
      core.alu_op    = ALU_AND;
      core.use_imm   = 1'b0;
      core.reg_write = 1'b0;
      core.mem_read  = 1'b0;
      core.mem_write = 1'b0;
      core.branch    = 1'b0;
      core.branch_ne = 1'b0;
      core.illegal   = 1'b1;
      imm_sel        = IMM_NONE;
    end
  end

  // Immediate is merged separately so the selector does not loop through one block
  always_comb begin
    dec     = core;
    dec.imm = imm_val;
  end

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      // skid_valid implies in_ready=0, so no accept can coincide with the refill
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= dec;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end else begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end
    end
  end

  assign out_valid     = main_valid;
  assign out_alu_op    = main_q.alu_op;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_use_imm   = main_q.use_imm;
  assign out_reg_write = main_q.reg_write;
  assign out_mem_read  = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_branch    = main_q.branch;
  assign out_branch_ne = main_q.branch_ne;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_rv64_decode_stage.sv
// tb/tb_rv64_decode_stage.sv - randomized self-checking bench for rv64_decode_stage
module tb_rv64_decode_stage;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_ne;
    logic        illegal;
    logic        chk_imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [63:0] out_imm;
  logic        out_use_imm, out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_branch_ne, out_illegal;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  rv64_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_branch_ne(out_branch_ne), .out_illegal(out_illegal)
  );

  function automatic logic [89:0] obs_vec();
    return {out_alu_op, out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_reg_write,
            out_mem_read, out_mem_write, out_branch, out_branch_ne, out_illegal};
  endfunction

  function automatic logic [89:0] exp_vec(exp_t e);
    return {e.alu_op, e.rs1, e.rs2, e.rd, e.imm, e.use_imm, e.reg_write,
            e.mem_read, e.mem_write, e.branch, e.branch_ne, e.illegal};
  endfunction

  // Illegal bundles only promise zeroed controls; legal ones promise everything
  function automatic logic [89:0] mask_of(exp_t e);
    if (e.illegal) return {4'hF, 15'h0, 64'h0, 1'b0, 4'hF, 1'b0, 1'b1};
    return {4'hF, 15'h7FFF, (e.chk_imm ? {64{1'b1}} : 64'h0), 7'h7F};
  endfunction

  // Builds an instruction from a randomly chosen mnemonic and states what it means
  task automatic gen(output logic [31:0] ins, output exp_t e);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [5:0]  sh, f6;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [3:0]  op;
    int          k;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    i12 = 12'($urandom); sh = 6'($urandom); b13 = {i12, 1'b0};
    f7 = 7'h00; f6 = 6'h00; f3 = 3'b000; op = 4'b0000;
    k = $urandom_range(0, 27);
    e = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.reg_write = 1'b1;
    if (k < 8) begin
      case (k)
        0: {f7, f3, op} = {7'h00, 3'b000, 4'b0010};
        1: {f7, f3, op} = {7'h20, 3'b000, 4'b0110};
        2: {f7, f3, op} = {7'h00, 3'b111, 4'b0000};
        3: {f7, f3, op} = {7'h00, 3'b110, 4'b0001};
        4: {f7, f3, op} = {7'h00, 3'b011, 4'b0111};
        5: {f7, f3, op} = {7'h00, 3'b001, 4'b1100};
        6: {f7, f3, op} = {7'h00, 3'b101, 4'b1101};
        default: {f7, f3, op} = {7'h20, 3'b101, 4'b1110};
      endcase
      ins = {f7, rs2, rs1, f3, rd, 7'b0110011};
      e.alu_op = op;
    end else if (k < 12) begin
      case (k)
        8:  {f3, op} = {3'b000, 4'b0010};
        9:  {f3, op} = {3'b111, 4'b0000};
        10: {f3, op} = {3'b110, 4'b0001};
        default: {f3, op} = {3'b011, 4'b0111};
      endcase
      ins = {i12, rs1, f3, rd, 7'b0010011};
      e.rs2 = i12[4:0]; e.alu_op = op; e.imm = 64'($signed(i12));
      e.use_imm = 1'b1; e.chk_imm = 1'b1;
    end else if (k < 15) begin
      case (k)
        12: {f6, f3, op} = {6'b000000, 3'b001, 4'b1100};
        13: {f6, f3, op} = {6'b000000, 3'b101, 4'b1101};
        default: {f6, f3, op} = {6'b010000, 3'b101, 4'b1110};
      endcase
      ins = {f6, sh, rs1, f3, rd, 7'b0010011};
      e.rs2 = sh[4:0]; e.alu_op = op; e.imm = 64'(sh);
      e.use_imm = 1'b1; e.chk_imm = 1'b1;
    end else if (k == 15) begin
      ins = {i12, rs1, 3'b011, rd, 7'b0000011};
      e.rs2 = i12[4:0]; e.alu_op = 4'b0010; e.imm = 64'($signed(i12));
      e.use_imm = 1'b1; e.mem_read = 1'b1; e.chk_imm = 1'b1;
    end else if (k == 16) begin
      ins = {i12[11:5], rs2, rs1, 3'b011, i12[4:0], 7'b0100011};
      e.rd = i12[4:0]; e.alu_op = 4'b0010; e.imm = 64'($signed(i12));
      e.use_imm = 1'b1; e.mem_write = 1'b1; e.reg_write = 1'b0; e.chk_imm = 1'b1;
    end else if (k < 19) begin
      f3 = (k == 18) ? 3'b001 : 3'b000;
      ins = {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'b1100011};
      e.rd = {b13[4:1], b13[11]}; e.alu_op = 4'b0110; e.imm = 64'($signed(b13));
      e.branch = 1'b1; e.branch_ne = (k == 18); e.reg_write = 1'b0; e.chk_imm = 1'b1;
    end else begin
      case (k)
        19: ins = {7'h00, rs2, rs1, 3'b100, rd, 7'b0110011};
        20: ins = {7'h00, rs2, rs1, 3'b010, rd, 7'b0110011};
        21: ins = {7'h00, rs2, rs1, 3'b000, rd, 7'b0111011};
        22: ins = {i12, rs1, 3'b000, rd, 7'b0110111};
        23: ins = {i12, rs1, 3'b000, rd, 7'b1101111};
        24: ins = {i12, rs1, 3'b010, rd, 7'b0000011};
        25: ins = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'b0100011};
        26: ins = {b13[12], b13[10:5], rs2, rs1, 3'b100, b13[4:1], b13[11], 7'b1100011};
        default: ins = {7'h01, rs2, rs1, 3'b000, rd, 7'b0110011};
      endcase
      e.illegal = 1'b1; e.reg_write = 1'b0; e.alu_op = 4'b0000;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (obs_vec() !== 90'h0) $display("FAIL reset_payload: got %h want 0", obs_vec()); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    in_valid = 1'b1; in_instr = 32'hFFF00293; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_alu_op !== 4'b0010) $display("FAIL addi_alu_op: got %b want 0010", out_alu_op); else n_pass++;
    n_checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL addi_imm: got %h want all ones", out_imm); else n_pass++;
    n_checks++; if ({out_rd, out_use_imm, out_reg_write} !== {5'd5, 1'b1, 1'b1})
      $display("FAIL addi_rd_flags: got %h want %h", {out_rd, out_use_imm, out_reg_write}, {5'd5, 2'b11}); else n_pass++;
    in_instr = 32'h402081B3;
    @(negedge clk);
    n_checks++; if ({out_alu_op, out_rs1, out_rs2, out_rd, out_use_imm} !== {4'b0110, 5'd1, 5'd2, 5'd3, 1'b0})
      $display("FAIL sub_fields: got %h want %h", {out_alu_op, out_rs1, out_rs2, out_rd, out_use_imm},
               {4'b0110, 5'd1, 5'd2, 5'd3, 1'b0}); else n_pass++;
    in_instr = 32'h43F0D093;
    @(negedge clk);
    n_checks++; if ({out_alu_op, out_imm, out_use_imm} !== {4'b1110, 64'd63, 1'b1})
      $display("FAIL srai_fields: alu %b imm %0d use_imm %b want 1110 63 1", out_alu_op, out_imm, out_use_imm); else n_pass++;
    in_instr = 32'h0020C1B3;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if ({out_illegal, out_reg_write, out_alu_op} !== {1'b1, 1'b0, 4'b0000})
      $display("FAIL xor_illegal: illegal %b reg_write %b alu %b want 1 0 0000", out_illegal, out_reg_write, out_alu_op); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_1: got %b want 1", in_ready); else n_pass++;
    @(negedge clk); in_instr = 32'h00200113;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_2: got %b want 1", in_ready); else n_pass++;
    @(negedge clk); in_instr = 32'h00300193;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_3: got %b want 0", in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if ({out_valid, out_rd, in_ready} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL b2b_hold: valid %b rd %0d in_ready %b want 1 1 0", out_valid, out_rd, in_ready); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({out_valid, out_rd, in_ready} !== {1'b1, 5'd2, 1'b1})
      $display("FAIL b2b_second: valid %b rd %0d in_ready %b want 1 2 1", out_valid, out_rd, in_ready); else n_pass++;
    @(negedge clk); in_valid = 1'b0;
    n_checks++; if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd3, 64'd3})
      $display("FAIL b2b_third: valid %b rd %0d imm %0d want 1 3 3", out_valid, out_rd, out_imm); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
    @(negedge clk); in_instr = 32'h00200113;
    @(negedge clk); in_instr = 32'h00300193; flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL flush_full: valid %b in_ready %b want 0 1", out_valid, in_ready); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_nothing_left: got %b want 0", out_valid); else n_pass++;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_drops_accept: got %b want 0", out_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_drops_later: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00293;
    @(negedge clk); in_instr = 32'h43F0D093;
    @(negedge clk); in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL arst_state: valid %b in_ready %b want 0 1", out_valid, in_ready); else n_pass++;
    n_checks++; if (obs_vec() !== 90'h0) $display("FAIL arst_payload: got %h want 0", obs_vec()); else n_pass++;
    @(negedge clk); rst = 1'b0;
    in_valid = 1'b1; in_instr = 32'h402081B3; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    n_checks++; if ({out_valid, out_alu_op, out_rs1, out_rs2, out_rd} !== {1'b1, 4'b0110, 5'd1, 5'd2, 5'd3})
      $display("FAIL arst_first: got %h want %h", {out_valid, out_alu_op, out_rs1, out_rs2, out_rd},
               {1'b1, 4'b0110, 5'd1, 5'd2, 5'd3}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] pend_ins = 32'h0;
    exp_t        pend_e = '0;
    exp_t        got_e;
    logic        pend = 1'b0, prev_stall = 1'b0, prev_flush = 1'b0, acc;
    logic [89:0] prev_obs = '0;
    q.delete();
    for (int c = 0; c < 900; c++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin gen(pend_ins, pend_e); pend = 1'b1; end
      in_valid = pend; in_instr = pend_ins;
      out_ready = ($urandom_range(0, 9) < 6);
      flush = (c < 860) && ($urandom_range(0, 39) == 0);
      #1;
      if (prev_stall) begin
        n_checks++;
        if ({out_valid, obs_vec()} !== {1'b1, prev_obs})
          $display("FAIL rand_stable c=%0d: got %b/%h want 1/%h", c, out_valid, obs_vec(), prev_obs); else n_pass++;
      end
      if (prev_flush) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rand_after_flush c=%0d: got %b want 0", c, out_valid); else n_pass++;
      end
      n_checks++;
      if (in_ready !== (q.size() < 2))
        $display("FAIL rand_in_ready c=%0d: got %b want %b", c, in_ready, (q.size() < 2)); else n_pass++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_extra_bundle c=%0d: got %h want none", c, obs_vec());
        else begin
          got_e = q.pop_front();
          if ((obs_vec() & mask_of(got_e)) !== (exp_vec(got_e) & mask_of(got_e)))
            $display("FAIL rand_bundle c=%0d: got %h want %h", c, obs_vec() & mask_of(got_e),
                     exp_vec(got_e) & mask_of(got_e));
          else n_pass++;
        end
      end
      acc = in_valid && in_ready;
      if (flush) q.delete();
      else if (acc) q.push_back(pend_e);
      if (acc) pend = 1'b0;
      prev_stall = out_valid && !out_ready && !flush;
      prev_obs = obs_vec();
      prev_flush = flush;
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL drain_extra_bundle: got %h want none", obs_vec());
        else begin
          got_e = q.pop_front();
          if ((obs_vec() & mask_of(got_e)) !== (exp_vec(got_e) & mask_of(got_e)))
            $display("FAIL drain_bundle: got %h want %h", obs_vec() & mask_of(got_e), exp_vec(got_e) & mask_of(got_e));
          else n_pass++;
        end
      end
      @(negedge clk);
    end
    n_checks++; if (q.size() != 0) $display("FAIL drain_lost: got %0d pending want 0", q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
